gpio_irq_arbiter: RTL and testbench

- Downstream of the GPIO edge-detect stage. Consumes its single-cycle interrupt pulses: irq_int0, irq_int1 and irq_pinchange.
- Latches each pulse into a pending register, flags overruns, and arbitrates by fixed priority.
- Presents one request line plus a vector to the CPU interrupt interface, with an ack handshake, ack timeout and post-service holdoff.

---
 rtl/gpio_irq_arbiter_if.sv | 10 +
 rtl/gpio_irq_arbiter.sv | 121 ++++++++++++
 tb/tb_gpio_irq_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_irq_arbiter_if.sv
// CPU-side interrupt handshake: request line, serviced-source vector and acknowledge.
// The master modport is the arbiter side; the slave modport is the CPU side.
interface gpio_irq_arbiter_if;
   logic       irq_req;
   logic [1:0] irq_vec;
   logic       irq_ack;

   modport master (output irq_req, output irq_vec, input irq_ack);
   modport slave  (input irq_req, input irq_vec, output irq_ack);
endinterface

// File: rtl/gpio_irq_arbiter.sv
// Latches GPIO interrupt pulses into pending/overrun flags and serves them to the CPU
// one at a time by fixed priority, with ack timeout and post-service holdoff.
module gpio_irq_arbiter #(
   parameter int unsigned ACK_TIMEOUT    = 255,
   parameter int unsigned HOLDOFF_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               irq_int0,
   input  logic               irq_int1,
   input  logic               irq_pinchange,
   input  logic [2:0]         src_en,
   input  logic [2:0]         pend_clr,
   input  logic               ovr_clr,
   gpio_irq_arbiter_if.master cpu,
   output logic [2:0]         pending,
   output logic [2:0]         overrun,
   output logic               ack_timeout
);

   localparam int unsigned HoldW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF_CYCLES - 1);
   localparam logic [15:0] TmoLast = 16'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

   state_e           state_q;
   logic [2:0]       pend_q;
   logic [2:0]       ovr_q;
   logic             tmo_flag_q;
   logic             req_q;
   logic [1:0]       vec_q;
   logic [15:0]      tmo_cnt_q;
   logic [HoldW-1:0] hold_cnt_q;

   logic [2:0] pulse;
   logic [2:0] clr;
   logic [2:0] ovr_evt;
   logic [2:0] eligible;
   logic [1:0] pick;
   logic       ack_hit;
   logic       withdraw;
   logic       tmo_evt;

   always_comb begin
      pulse    = {irq_pinchange, irq_int1, irq_int0};
      ack_hit  = (state_q == StReq) && cpu.irq_ack;
      clr      = pend_clr | (ack_hit ? (3'b001 << vec_q) : 3'b000);
      // A same-cycle pulse beats any clear and is not an overrun.
      ovr_evt  = pulse & pend_q & ~clr;
      eligible = pend_q & src_en;
      pick     = 2'd0;
      if (eligible[0]) begin
         pick = 2'd0;
      end else if (eligible[1]) begin
         pick = 2'd1;
      end else if (eligible[2]) begin
         pick = 2'd2;
      end
      withdraw = (state_q == StReq) && !ack_hit && pend_clr[vec_q] && !pulse[vec_q];
      tmo_evt  = (state_q == StReq) && !ack_hit && !withdraw && (tmo_cnt_q == TmoLast);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         pend_q     <= 3'b000;
         ovr_q      <= 3'b000;
         tmo_flag_q <= 1'b0;
         req_q      <= 1'b0;
         vec_q      <= 2'd0;
         tmo_cnt_q  <= 16'd0;
         hold_cnt_q <= '0;
      end else begin
         pend_q     <= pulse | (pend_q & ~clr);
         ovr_q      <= ovr_evt | (ovr_q & {3{~ovr_clr}});
         tmo_flag_q <= tmo_evt | (tmo_flag_q & ~ovr_clr);
         case (state_q)
            StIdle: begin
               if (eligible != 3'b000) begin
                  vec_q     <= pick;
                  tmo_cnt_q <= 16'd0;
                  req_q     <= 1'b1;
                  state_q   <= StReq;
               end
            end
            StReq: begin
               if (ack_hit || tmo_evt) begin
                  req_q      <= 1'b0;
                  hold_cnt_q <= '0;
                  // With no holdoff, IDLE itself provides the single quiet cycle.
                  state_q    <= (HOLDOFF_CYCLES == 0) ? StIdle : StHold;
               end else if (withdraw) begin
                  req_q   <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
               end
            end
            StHold: begin
               if (hold_cnt_q == HoldLast) begin
                  state_q <= StIdle;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign cpu.irq_req = req_q;
   assign cpu.irq_vec = vec_q;
   assign pending     = pend_q;
   assign overrun     = ovr_q;
   assign ack_timeout = tmo_flag_q;

endmodule

// File: tb/tb_gpio_irq_arbiter.sv
// Bench for gpio_irq_arbiter: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the pending/request rules.
module tb_gpio_irq_arbiter;

   localparam int TMO  = 4;
   localparam int HOLD = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       irq_int0 = 1'b0, irq_int1 = 1'b0, irq_pinchange = 1'b0;
   logic [2:0] src_en = 3'b000, pend_clr = 3'b000;
   logic       ovr_clr = 1'b0;
   logic [2:0] pending, overrun;
   logic       ack_timeout;

   gpio_irq_arbiter_if cpu_if ();

   gpio_irq_arbiter #(.ACK_TIMEOUT(TMO), .HOLDOFF_CYCLES(HOLD)) dut (
      .clk           (clk),
      .reset         (reset),
      .irq_int0      (irq_int0),
      .irq_int1      (irq_int1),
      .irq_pinchange (irq_pinchange),
      .src_en        (src_en),
      .pend_clr      (pend_clr),
      .ovr_clr       (ovr_clr),
      .cpu           (cpu_if.master),
      .pending       (pending),
      .overrun       (overrun),
      .ack_timeout   (ack_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: request is up or not, how old it is, and how many quiet
   // cycles must still pass before the next arbitration.
   bit [2:0] m_pend = 0, m_ovr = 0;
   bit       m_tmo = 0, m_req = 0;
   int       m_vec = 0, m_age = 0, m_quiet = 0;

   task automatic model_step();
      bit [2:0] pulse, clr, ovr_new, elig;
      bit       acked, tmo_now;
      pulse   = {irq_pinchange, irq_int1, irq_int0};
      tmo_now = 0;
      if (reset) begin
         m_pend = 0; m_ovr = 0; m_tmo = 0; m_req = 0;
         m_vec = 0; m_age = 0; m_quiet = 0;
         return;
      end
      acked = m_req && cpu_if.irq_ack;
      clr   = pend_clr;
      if (acked) clr[m_vec] = 1'b1;
      ovr_new = pulse & m_pend & ~clr;
      elig    = m_pend & src_en;
      if (m_req) begin
         if (acked) begin
            m_req = 0; m_quiet = HOLD;
         end else if (pend_clr[m_vec] && !pulse[m_vec]) begin
            m_req = 0; m_quiet = 0;
         end else if (m_age == TMO - 1) begin
            m_req = 0; m_quiet = HOLD; tmo_now = 1;
         end else begin
            m_age++;
         end
      end else if (m_quiet > 0) begin
         m_quiet--;
      end else if (elig != 0) begin
         for (int i = 2; i >= 0; i--) if (elig[i]) m_vec = i;
         m_req = 1; m_age = 0;
      end
      m_ovr  = ovr_clr ? ovr_new : (m_ovr | ovr_new);
      m_tmo  = tmo_now | (m_tmo & !ovr_clr);
      m_pend = pulse | (m_pend & ~clr);
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_eq("m_req", {31'b0, cpu_if.irq_req}, {31'b0, m_req});
      check_eq("m_vec", {30'b0, cpu_if.irq_vec}, 32'(m_vec));
      check_eq("m_pending", {29'b0, pending}, {29'b0, m_pend});
      check_eq("m_overrun", {29'b0, overrun}, {29'b0, m_ovr});
      check_eq("m_ack_timeout", {31'b0, ack_timeout}, {31'b0, m_tmo});
   endtask

   task automatic clear_in();
      irq_int0 = 0; irq_int1 = 0; irq_pinchange = 0;
      pend_clr = 0; ovr_clr = 0; cpu_if.irq_ack = 0;
   endtask

   task automatic do_reset();
      clear_in();
      reset = 1;
      step();
      reset = 0;
   endtask

   initial begin
      int n;
      clear_in();
      src_en = 3'b111;
      do_reset();
      check_eq("reset_req", {31'b0, cpu_if.irq_req}, 0);
      check_eq("reset_pending", {29'b0, pending}, 0);

      // Single irq_int1 pulse, ack three cycles after the request rises.
      irq_int1 = 1; step(); irq_int1 = 0;
      check_eq("s1_pend", {29'b0, pending}, 32'b010);
      check_eq("s1_req_early", {31'b0, cpu_if.irq_req}, 0);
      step();
      check_eq("s1_req", {31'b0, cpu_if.irq_req}, 1);
      check_eq("s1_vec", {30'b0, cpu_if.irq_vec}, 1);
      step(); step();
      cpu_if.irq_ack = 1; step(); cpu_if.irq_ack = 0;
      check_eq("s1_req_ack", {31'b0, cpu_if.irq_req}, 0);
      check_eq("s1_pend_ack", {29'b0, pending}, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("s1_quiet", {31'b0, cpu_if.irq_req}, 0);
      end

      // All three sources at once: served 0, 1, 2.
      do_reset();
      irq_int0 = 1; irq_int1 = 1; irq_pinchange = 1; step(); clear_in();
      for (int v = 0; v < 3; v++) begin
         n = 0;
         while (!cpu_if.irq_req && n < 20) begin step(); n++; end
         check_eq("s2_req", {31'b0, cpu_if.irq_req}, 1);
         check_eq("s2_vec", {30'b0, cpu_if.irq_vec}, 32'(v));
         cpu_if.irq_ack = 1; step(); cpu_if.irq_ack = 0;
      end
      check_eq("s2_overrun", {29'b0, overrun}, 0);

      // Double pinchange pulse: overrun, then ovr_clr.
      src_en = 3'b000;
      do_reset();
      irq_pinchange = 1; step(); irq_pinchange = 0; step();
      irq_pinchange = 1; step(); irq_pinchange = 0;
      check_eq("s3_pend2", {31'b0, pending[2]}, 1);
      check_eq("s3_ovr", {29'b0, overrun}, 32'b100);
      ovr_clr = 1; step(); ovr_clr = 0;
      check_eq("s3_ovr_clr", {29'b0, overrun}, 0);

      // Ack timeout after exactly TMO request cycles, then re-request.
      src_en = 3'b111;
      do_reset();
      irq_int0 = 1; step(); irq_int0 = 0; step();
      n = 0;
      while (cpu_if.irq_req && n < 50) begin n++; step(); end
      check_eq("s4_req_cycles", 32'(n), 32'(TMO));
      check_eq("s4_tmo", {31'b0, ack_timeout}, 1);
      check_eq("s4_pend0", {31'b0, pending[0]}, 1);
      step(); step();
      check_eq("s4_hold", {31'b0, cpu_if.irq_req}, 0);
      step();
      check_eq("s4_rereq", {31'b0, cpu_if.irq_req}, 1);
      check_eq("s4_revec", {30'b0, cpu_if.irq_vec}, 0);

      // Withdraw via pend_clr.
      do_reset();
      irq_int1 = 1; step(); irq_int1 = 0; step();
      check_eq("s5_vec", {30'b0, cpu_if.irq_vec}, 1);
      pend_clr = 3'b010; step(); pend_clr = 0;
      check_eq("s5_withdraw", {31'b0, cpu_if.irq_req}, 0);
      check_eq("s5_no_tmo", {31'b0, ack_timeout}, 0);

      // Ack and new pulse in the same cycle.
      do_reset();
      irq_int1 = 1; step(); irq_int1 = 0; step();
      cpu_if.irq_ack = 1; irq_int1 = 1; step(); clear_in();
      check_eq("s6_pend1", {31'b0, pending[1]}, 1);
      check_eq("s6_ovr", {29'b0, overrun}, 0);
      step(); step();
      check_eq("s6_hold", {31'b0, cpu_if.irq_req}, 0);
      step();
      check_eq("s6_rereq", {31'b0, cpu_if.irq_req}, 1);

      // Masked source, then enable, then reset mid-request.
      src_en = 3'b000;
      do_reset();
      irq_int0 = 1; step(); irq_int0 = 0; step();
      check_eq("s7_pend", {29'b0, pending}, 32'b001);
      check_eq("s7_masked", {31'b0, cpu_if.irq_req}, 0);
      src_en = 3'b001; step();
      check_eq("s7_req", {31'b0, cpu_if.irq_req}, 1);
      reset = 1; step(); reset = 0;
      check_eq("s7_rst_req", {31'b0, cpu_if.irq_req}, 0);
      check_eq("s7_rst_pend", {29'b0, pending}, 0);

      // Random traffic.
      for (int c = 0; c < 4000; c++) begin
         irq_int0       = ($urandom_range(5) == 0);
         irq_int1       = ($urandom_range(5) == 0);
         irq_pinchange  = ($urandom_range(5) == 0);
         pend_clr       = ($urandom_range(9) == 0) ? 3'($urandom) : 3'b000;
         ovr_clr        = ($urandom_range(15) == 0);
         cpu_if.irq_ack = ($urandom_range(2) == 0);
         if ($urandom_range(19) == 0) src_en = 3'($urandom);
         reset          = ($urandom_range(499) == 0);
         step();
      end
      clear_in();
      reset = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
